// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the 8N1 UART receiver: assembles [SOF][LEN][PAYLOAD][CHK] frames,
// checks the XOR checksum and holds the payload until the consumer releases it.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SOF           = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          err_len,
  output logic          err_chk,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam longint unsigned ToCyclesL =
      (64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_HZ)) / 64'(BAUD_RATE);
  localparam int unsigned TO      = 32'(ToCyclesL);
  localparam int unsigned TmoW    = $clog2(TO + 1);
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic [LW-1:0]   pkt_len_q, pkt_len_d;
  logic            err_len_q, err_len_d;
  logic            err_chk_q, err_chk_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic            buf_we;
  logic            in_frame;
  logic            last_byte;

  assign in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  assign last_byte = (8'(idx_q) == (8'(len_q) - 8'd1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    tmo_d         = '0;
    pkt_valid_d   = pkt_valid_q;
    pkt_len_d     = pkt_len_q;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    buf_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SOF)) state_d = StLen;
      end
      StLen: begin
        if (rx_valid) begin
          chk_d = rx_data;
          idx_d = '0;
          if ((rx_data == 8'd0) || (rx_data > MaxLenB)) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else begin
            len_d   = rx_data[LW-1:0];
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          // idx stays on the last slot so it never leaves the buffer range
          if (last_byte) state_d = StChk;
          else           idx_d   = idx_q + AW'(1);
        end
      end
      StChk: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d     = StHold;
            pkt_valid_d = 1'b1;
            pkt_len_d   = len_q;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StHold: begin
        // A release and a new SOF may share a cycle; the byte is then taken as in idle.
        if (pkt_ready) begin
          pkt_valid_d = 1'b0;
          state_d     = (rx_valid && (rx_data == SOF)) ? StLen : StIdle;
        end else if (rx_valid) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte in the expiry cycle takes priority over the timeout.
    if (in_frame && !rx_valid) begin
      if (tmo_q == TmoW'(TO - 1)) begin
        err_timeout_d = 1'b1;
        state_d       = StIdle;
        tmo_d         = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      tmo_q         <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_len_q     <= '0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      tmo_q         <= tmo_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_len_q     <= pkt_len_d;
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      if (buf_we) buf_q[idx_q] <= rx_data;
    end
  end

  assign pkt_valid   = pkt_valid_q;
  assign pkt_len     = pkt_len_q;
  assign busy        = in_frame;
  assign err_len     = err_len_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
  assign rd_data     = (32'(rd_addr) < MAX_LEN) ? buf_q[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed scenarios plus random frame traffic, all checked
// every cycle against a byte-stream reference model.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam longint     TO_L    = 64'd4 * 64'd10 * 64'd50_000_000 / 64'd96000;
  localparam int         TO      = int'(TO_L);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pkt_ready = 1'b0;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       pkt_valid, busy, err_len, err_chk, err_timeout, err_overrun;

  uart_rx_frame_ctrl #(
    .BAUD_RATE(96000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .err_len    (err_len),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: frame bytes collected in a queue, idle gap counted since the last byte.
  logic [7:0] fq[$];
  logic [7:0] mbuf [MAX_LEN];
  bit         in_frame, held;
  int         gap;
  bit         e_valid, e_busy, e_err_len, e_err_chk, e_err_to, e_err_ov;
  int         e_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic start_frame();
    in_frame = 1'b1;
    gap      = 0;
    fq.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy, input bit r);
    logic [7:0] x;
    e_err_len = 0; e_err_chk = 0; e_err_to = 0; e_err_ov = 0;
    if (r) begin
      held = 0; in_frame = 0; e_valid = 0; e_len = 0; gap = 0;
      fq.delete();
      for (int i = 0; i < MAX_LEN; i++) mbuf[i] = 8'h00;
    end else if (held) begin
      if (rdy) begin
        held = 0; e_valid = 0;
        if (v && d == SOF) start_frame();
      end else if (v) begin
        e_err_ov = 1;
      end
    end else if (in_frame) begin
      if (v) begin
        gap = 0;
        fq.push_back(d);
        if (fq.size() == 1) begin
          if (d == 0 || int'(d) > MAX_LEN) begin e_err_len = 1; in_frame = 0; end
        end else if (fq.size() <= int'(fq[0]) + 1) begin
          mbuf[fq.size() - 2] = d;
        end else begin
          x = 8'h00;
          for (int i = 0; i < fq.size() - 1; i++) x ^= fq[i];
          if (x == d) begin held = 1; e_valid = 1; e_len = int'(fq[0]); end
          else e_err_chk = 1;
          in_frame = 0;
        end
      end else begin
        gap++;
        if (gap == TO) begin e_err_to = 1; in_frame = 0; end
      end
    end else if (v && d == SOF) begin
      start_frame();
    end
    e_busy = in_frame;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pkt_valid", pkt_valid, e_valid);
      chk("pkt_len", pkt_len, e_len);
      chk("busy", busy, e_busy);
      chk("err_len", err_len, e_err_len);
      chk("err_chk", err_chk, e_err_chk);
      chk("err_timeout", err_timeout, e_err_to);
      chk("err_overrun", err_overrun, e_err_ov);
      chk("err_exclusive", 32'($countones({err_len, err_chk, err_timeout, err_overrun})) > 1, 0);
      chk("valid_vs_frame_err", pkt_valid & (err_len | err_chk | err_timeout), 0);
      if (e_valid && int'(rd_addr) < e_len) chk("rd_data", rd_data, mbuf[rd_addr]);
    end
  end

  task automatic tick(input bit v, input logic [7:0] d, input bit rdy, input bit r);
    rx_valid  = v;
    rx_data   = d;
    pkt_ready = rdy;
    rst       = r;
    rd_addr   = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_step(v, d, rdy, r);
    #1;
    rx_valid  = 1'b0;
    pkt_ready = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic rd_check(input string name, input int a, input logic [7:0] e);
    rd_addr = 4'(a);
    #1;
    chk(name, rd_data, e);
  endtask

  task automatic rand_send(input logic [7:0] d);
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) tick(1'b0, 8'h00, $urandom_range(0, 3) == 0, 1'b0);
    tick(1'b1, d, $urandom_range(0, 3) == 0, 1'b0);
  endtask

  initial begin
    // Reset
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    cmp_en = 1'b1;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", pkt_len, 0);
    @(negedge clk); #1;
    rd_check("rst_buf0", 0, 8'h00);
    rd_check("rst_buf15", 15, 8'h00);

    // Basic frame: checksum is LEN ^ payload = 03^11^22^33 = 03
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("t1_busy_chk", busy, 1);
    send(8'h03);
    chk("t1_valid", pkt_valid, 1);
    chk("t1_len", pkt_len, 3);
    chk("t1_busy", busy, 0);
    @(negedge clk); #1;
    rd_check("t1_rd0", 0, 8'h11);
    rd_check("t1_rd1", 1, 8'h22);
    rd_check("t1_rd2", 2, 8'h33);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_release", pkt_valid, 0);

    // Bad checksum, then a good frame
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    chk("t2_err_chk", err_chk, 1);
    chk("t2_valid", pkt_valid, 0);
    idle(1, 1'b0);
    chk("t2_err_pulse", err_chk, 0);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54);
    chk("t2_next_valid", pkt_valid, 1);
    @(negedge clk); #1;
    rd_check("t2_rd0", 0, 8'h55);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Length errors
    send(8'hA5); send(8'h00);
    chk("t3_len0", err_len, 1);
    send(8'hA5); send(8'h11);
    chk("t3_len17", err_len, 1);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    chk("t3_after_valid", pkt_valid, 1);
    chk("t3_after_len", pkt_len, 2);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Timeout, then a byte landing on the expiry cycle
    send(8'hA5); send(8'h04); send(8'h01);
    idle(TO - 1, 1'b0);
    chk("t4_before_to", err_timeout, 0);
    idle(1, 1'b0);
    chk("t4_timeout", err_timeout, 1);
    chk("t4_busy", busy, 0);
    send(8'hA5); send(8'h04); send(8'h01);
    idle(TO - 1, 1'b0);
    send(8'h02);
    chk("t4_byte_wins", err_timeout, 0);
    chk("t4_still_busy", busy, 1);
    send(8'h03); send(8'h04); send(8'h00);
    chk("t4_valid", pkt_valid, 1);

    // Overrun while held, then release together with a new SOF
    for (int i = 0; i < 3; i++) begin
      send(8'h5A + 8'(i));
      chk("t5_overrun", err_overrun, 1);
      chk("t5_held", pkt_valid, 1);
    end
    idle(1, 1'b0);
    chk("t5_ov_pulse", err_overrun, 0);
    @(negedge clk); #1;
    rd_check("t5_rd0", 0, 8'h01);
    rd_check("t5_rd1", 1, 8'h02);
    rd_check("t5_rd2", 2, 8'h03);
    rd_check("t5_rd3", 3, 8'h04);
    chk("t5_len", pkt_len, 4);
    tick(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("t5_rel_valid", pkt_valid, 0);
    chk("t5_rel_busy", busy, 1);
    chk("t5_rel_no_ov", err_overrun, 0);
    send(8'h01); send(8'h66); send(8'h67);
    chk("t5_new_valid", pkt_valid, 1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-payload
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_valid", pkt_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_len", pkt_len, 0);
    chk("t6_errs", {err_len, err_chk, err_timeout, err_overrun}, 0);
    @(negedge clk); #1;
    rd_check("t6_rd0", 0, 8'h00);
    rd_check("t6_rd1", 1, 8'h00);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("t6_valid_after", pkt_valid, 1);
    @(negedge clk); #1;
    rd_check("t6_rd_after", 0, 8'h7E);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic
    for (int f = 0; f < 250; f++) begin
      int         kind;
      int         len;
      logic [7:0] x;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAX_LEN);
      if (kind == 0) begin
        rand_send(8'($urandom_range(0, 255)));
      end else if (kind == 1) begin
        rand_send(SOF);
        if ($urandom_range(0, 1) == 0) rand_send(8'h00);
        else rand_send(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        rand_send(SOF);
        rand_send(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          x ^= b;
          rand_send(b);
          if (kind == 3 && i == len / 2) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            break;
          end
        end
        if (kind == 2) rand_send(x ^ 8'($urandom_range(1, 255)));
        else if (kind != 3) rand_send(x);
      end
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        b = ($urandom_range(0, 3) == 0) ? SOF : 8'($urandom_range(0, 255));
        tick($urandom_range(0, 2) == 0, b, $urandom_range(0, 3) == 0, 1'b0);
      end
    end
    idle(4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
